// File: rtl/i2c_seq_writer_if.sv
// I2C pad bundle: synchronised SCL/SDA line values and open-drain pull-down enables.
interface i2c_seq_writer_if;
   logic scl_in;
   logic sda_in;
   logic scl_oe;
   logic sda_oe;

   modport master (
      input  scl_in,
      input  sda_in,
      output scl_oe,
      output sda_oe
   );

   modport slave (
      output scl_in,
      output sda_in,
      input  scl_oe,
      input  sda_oe
   );
endinterface

// File: rtl/i2c_seq_writer.sv
// Open-drain I2C master that replays a latched table of {reg, data} writes
// to one slave, with ACK checking, clock stretching and an inter-write gap.
module i2c_seq_writer #(
   parameter int         CLK_DIV    = 5,
   parameter int         NUM_WRITES = 4,
   parameter logic [6:0] SLAVE_ADDR = 7'h74,
   parameter int         GAP_CYCLES = 50000
) (
   input  logic                     s_clk_25mhz,
   input  logic                     s_rst_n,
   input  logic                     start,
   input  logic [NUM_WRITES*16-1:0] cfg_table,
   i2c_seq_writer_if.master         i2c,
   output logic                     busy,
   output logic                     done,
   output logic                     nack,
   output logic [3:0]               nack_index,
   output logic [3:0]               write_idx
);
   localparam int CW = $clog2(CLK_DIV + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_ADDR  = 3'd2;
   localparam logic [2:0] S_REG   = 3'd3;
   localparam logic [2:0] S_DATA  = 3'd4;
   localparam logic [2:0] S_ACK   = 3'd5;
   localparam logic [2:0] S_STOP  = 3'd6;
   localparam logic [2:0] S_GAP   = 3'd7;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    qtr_q, qtr_d;
   logic [2:0]    bit_q, bit_d;
   logic [1:0]    byte_q, byte_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [3:0]    idx_q, idx_d;
   logic [255:0]  tbl_q, tbl_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          nack_q, nack_d;
   logic [3:0]    nidx_q, nidx_d;

   logic          running;
   logic          hold;
   logic          tick;
   logic          qend;
   logic [15:0]   entry;
   logic [7:0]    tx_byte;
   logic          tx_bit;
   logic          scl_oe_c;
   logic          sda_oe_c;

   assign running = (state_q != S_IDLE) && (state_q != S_GAP);
   // A slave holding SCL low freezes the quarter counter at the start of Q2.
   assign hold    = (qtr_q == 2'd2) && !i2c.scl_in;
   assign tick    = running && !hold && (cnt_q == CW'(CLK_DIV - 1));
   assign qend    = tick && (qtr_q == 2'd3);
   assign entry   = tbl_q[{idx_q, 4'b0000} +: 16];
   assign tx_bit  = tx_byte[~bit_q];

   always_comb begin
      unique case (byte_q)
         2'd0:    tx_byte = {SLAVE_ADDR, 1'b0};
         2'd1:    tx_byte = entry[15:8];
         default: tx_byte = entry[7:0];
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      qtr_d   = qtr_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      gap_d   = gap_q;
      idx_d   = idx_q;
      tbl_d   = tbl_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      nack_d  = nack_q;
      nidx_d  = nidx_q;

      if (running && !hold) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
         if (tick) qtr_d = qtr_q + 2'd1;
      end

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_START;
               tbl_d   = 256'(cfg_table);
               idx_d   = 4'd0;
               nack_d  = 1'b0;
               busy_d  = 1'b1;
               cnt_d   = '0;
               qtr_d   = 2'd0;
            end
         end
         S_START: begin
            if (qend) begin
               state_d = S_ADDR;
               bit_d   = 3'd0;
               byte_d  = 2'd0;
            end
         end
         S_ADDR, S_REG, S_DATA: begin
            if (qend) begin
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = S_ACK;
            end
         end
         S_ACK: begin
            if (qend) begin
               if (i2c.sda_in) begin
                  nack_d  = 1'b1;
                  nidx_d  = idx_q;
                  state_d = S_STOP;
               end else begin
                  unique case (byte_q)
                     2'd0:    state_d = S_REG;
                     2'd1:    state_d = S_DATA;
                     default: state_d = S_STOP;
                  endcase
                  byte_d = byte_q + 2'd1;
               end
            end
         end
         S_STOP: begin
            if (qend) begin
               if (nack_q || idx_q == 4'(NUM_WRITES - 1)) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  state_d = S_GAP;
                  gap_d   = '0;
               end
            end
         end
         default: begin
            if (gap_q == GW'(GAP_CYCLES - 1)) begin
               state_d = S_START;
               idx_d   = idx_q + 4'd1;
               cnt_d   = '0;
               qtr_d   = 2'd0;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      scl_oe_c = 1'b0;
      sda_oe_c = 1'b0;
      unique case (state_q)
         S_START: sda_oe_c = qtr_q[1];
         S_ADDR, S_REG, S_DATA: begin
            scl_oe_c = ~qtr_q[1];
            sda_oe_c = ~tx_bit;
         end
         S_ACK:   scl_oe_c = ~qtr_q[1];
         S_STOP: begin
            scl_oe_c = ~qtr_q[1];
            sda_oe_c = (qtr_q != 2'd3);
         end
         default: ;
      endcase
   end

   assign i2c.scl_oe = scl_oe_c;
   assign i2c.sda_oe = sda_oe_c;
   assign busy       = busy_q;
   assign done       = done_q;
   assign nack       = nack_q;
   assign nack_index = nidx_q;
   assign write_idx  = idx_q;

   always_ff @(posedge s_clk_25mhz or negedge s_rst_n) begin
      if (!s_rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         qtr_q   <= 2'd0;
         bit_q   <= 3'd0;
         byte_q  <= 2'd0;
         gap_q   <= '0;
         idx_q   <= 4'd0;
         tbl_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         nack_q  <= 1'b0;
         nidx_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         qtr_q   <= qtr_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         gap_q   <= gap_d;
         idx_q   <= idx_d;
         tbl_q   <= tbl_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         nack_q  <= nack_d;
         nidx_q  <= nidx_d;
      end
   end
endmodule

// File: doc/i2c_seq_writer.md
# i2c_seq_writer

Parametrised I2C write sequencer for ROIC/gate-driver register configuration. Drives the bus as a true open-drain master and replays a table of NUM_WRITES register writes (slave address, register byte, data byte) on a single `start` pulse. It checks every ACK, honours clock stretching, inserts a programmable gap between writes and reports completion or NACK. It sits between the configuration logic (which supplies `gate_gpio_data`-derived table entries) and the board SCL/SDA pads.

## Interface
Parameters:
- `CLK_DIV`, 5: clock cycles per quarter-bit. Bit period is 4*CLK_DIV cycles (1.25 MHz SCL at 25 MHz).
- `NUM_WRITES`, 4: number of table entries, range 1..16.
- `SLAVE_ADDR`, 7'h74: 7-bit slave address. The address byte sent is {SLAVE_ADDR, 1'b0}, i.e. 8'hE8.
- `GAP_CYCLES`, 50000: idle cycles between consecutive writes (2 ms at 25 MHz). Minimum 1.

Ports:
- `s_clk_25mhz`, input, 1: the only clock. All logic runs on its rising edge.
- `s_rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: one-cycle pulse that starts the sequence. Ignored while `busy`.
- `cfg_table`, input, NUM_WRITES*16: entry k is `cfg_table[16k+15:16k]`, laid out as {reg[7:0], data[7:0]}. The whole table is latched on an accepted `start`.
- `scl_in`, input, 1: synchronised pad value of SCL.
- `sda_in`, input, 1: synchronised pad value of SDA.
- `scl_oe`, output, 1: 1 pulls SCL low, 0 releases it.
- `sda_oe`, output, 1: 1 pulls SDA low, 0 releases it.
- `busy`, output, 1: high from the cycle after an accepted `start` until `done`.
- `done`, output, 1: one-cycle pulse at the end of the sequence, whether it completed or aborted.
- `nack`, output, 1: sticky error flag. Set on any NACK. Cleared by the next accepted `start`.
- `nack_index`, output, 4: index of the entry that NACKed. Valid while `nack`=1.
- `write_idx`, output, 4: index of the entry currently being sent.

## Operation
- Reset values: `scl_oe`=0, `sda_oe`=0, `busy`=0, `done`=0, `nack`=0, `nack_index`=0, `write_idx`=0, state IDLE.
- Reset asserted mid-transfer releases both lines immediately and returns to IDLE. No STOP is generated.
- A quarter counter produces one tick every CLK_DIV cycles while the block is not in IDLE or GAP. Every bus phase below lasts 4 quarters, Q0..Q3.
- States: IDLE, START, ADDR, REG, DATA, ACK, STOP, GAP.
  - IDLE -> START on an accepted `start`. The table is latched, `write_idx` is set to 0 and `nack` is cleared.
  - START: Q0–Q1 release both lines. Q2–Q3 set `sda_oe`=1 with SCL still released.
  - ADDR, REG, DATA: 8 bits each, MSB first. Per bit: Q0 sets `scl_oe`=1 and drives SDA (`sda_oe`=~bit); Q1 holds; Q2–Q3 release SCL.
  - Each byte is followed by an ACK bit: SDA released, `sda_in` sampled on the last cycle of Q3. Sample 0 = ACK, continue to the next byte or to STOP. Sample 1 = NACK: set `nack`=1 and `nack_index`=`write_idx`, then go to STOP and abort the remaining entries.
  - STOP: Q0–Q1 SCL low and SDA low. Q2 releases SCL. Q3 releases SDA.
  - After STOP:
    - NACK occurred, or the last entry was sent: pulse `done`, drop `busy`, go to IDLE.
    - Otherwise: go to GAP for GAP_CYCLES cycles with both lines released, then increment `write_idx` and go to START.
- Clock stretching: at Q2, once SCL is released, the quarter counter holds until `scl_in`=1 and only then counts Q2. There is no timeout.
- A `start` pulse in any state other than IDLE is ignored and has no side effects.

## Timing
- Accepted `start` at cycle 0: `busy`=1 at cycle 1. The first START quarter begins at cycle 1.
- One write without stretching is (4 + 27*4 + 4)*CLK_DIV = 116*CLK_DIV cycles, which is 580 cycles at the default.
- Full sequence: NUM_WRITES*116*CLK_DIV + (NUM_WRITES-1)*GAP_CYCLES cycles. `done` is asserted in the cycle after the final STOP Q3 ends.
- SDA changes only while SCL is low, except for the SDA transitions that form START and STOP.
- Every cycle spent stretching adds exactly one cycle to the affected bit.

## Test plan
- Single write (NUM_WRITES=1, entry {8'h06, 8'h00}), slave always ACKs -> decoded bus bytes are E8, 06, 00. `done` arrives at cycle 581 and `nack`=0.
- Default 4-entry table {06,00}, {02,A5}, {07,00}, {03,3C}, GAP_CYCLES=100 -> four START/STOP frames in order with exactly 100 idle cycles between them. `write_idx` steps 0 to 3. `done` arrives once.
- Slave NACKs the data byte of entry 1 -> STOP immediately after that ACK bit. `nack`=1, `nack_index`=1, `done` pulses, and no further START is generated.
- Slave holds `scl_in` low for 37 cycles during bit 3 of REG -> that bit lasts 20+37 cycles and all later bus timing shifts by 37 cycles.
- `start` pulsed again mid-sequence -> ignored. The table is not relatched and `nack` is unchanged.
- `s_rst_n` asserted during ADDR bit 5 -> `scl_oe`, `sda_oe` and `busy` read 0 in the same cycle. After release, a new `start` produces a clean full transfer.
